// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage and its IF/ID register.
package if_fetch_stage_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP     = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP,
        BUF
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{pc: '0, instr: NOP, valid: 1'b0};

    // Sequential fetch increment; wraps modulo 2^32.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats freeze, freeze holds, otherwise loads a
// new entry or a bubble when the fetch side has nothing to hand over.
module if_id_reg
    import if_fetch_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   freeze,
    input  logic   flush,
    input  logic   load,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= IF_ID_BUBBLE;
        end else if (flush) begin
            q <= IF_ID_BUBBLE;
        end else if (!freeze) begin
            q <= load ? d : IF_ID_BUBBLE;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, branch redirect with
// drop of in-flight responses, and a one-entry skid buffer for stalls.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               if_id_valid
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    if_id_t            skid_q, skid_d;

    logic              idr_flush;
    logic              idr_hold;
    logic              idr_load;
    if_id_t            idr_d;
    if_id_t            idr_q;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] addr_inc;

    assign pc_inc   = next_pc(pc_q);
    assign addr_inc = next_pc(addr_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            skid_q  <= IF_ID_BUBBLE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            skid_q  <= skid_d;
        end
    end

    // pc is the next address to fetch; addr is what the bus currently sees.
    // They only differ in DROP, where the bus still waits on a stale request.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        skid_d    = skid_q;
        idr_flush = 1'b0;
        idr_hold  = freeze;
        idr_load  = 1'b0;
        idr_d     = IF_ID_BUBBLE;

        case (state_q)
            IDLE: begin
                state_d = WAIT;
                if (branch_taken) begin
                    idr_flush = 1'b1;
                    pc_d      = branch_addr;
                    addr_d    = branch_addr;
                end
            end

            WAIT: begin
                if (branch_taken) begin
                    idr_flush = 1'b1;
                    pc_d      = branch_addr;
                    if (imem_ack) begin
                        addr_d = branch_addr;
                    end else begin
                        state_d = DROP;
                    end
                end else if (imem_ack) begin
                    pc_d   = pc_inc;
                    addr_d = pc_inc;
                    if (freeze) begin
                        skid_d  = '{pc: addr_inc, instr: imem_rdata, valid: 1'b1};
                        state_d = BUF;
                    end else begin
                        idr_load = 1'b1;
                        idr_d    = '{pc: addr_inc, instr: imem_rdata, valid: 1'b1};
                    end
                end
            end

            DROP: begin
                if (branch_taken) begin
                    idr_flush = 1'b1;
                    pc_d      = branch_addr;
                end else if (imem_ack) begin
                    addr_d  = pc_q;
                    state_d = WAIT;
                end
            end

            BUF: begin
                // The next request is deliberately not issued until the
                // buffered word drains, so at most one word is ever parked.
                if (branch_taken) begin
                    idr_flush = 1'b1;
                    skid_d    = IF_ID_BUBBLE;
                    pc_d      = branch_addr;
                    addr_d    = branch_addr;
                    state_d   = WAIT;
                end else if (!freeze) begin
                    idr_load = 1'b1;
                    idr_d    = skid_q;
                    skid_d   = IF_ID_BUBBLE;
                    state_d  = WAIT;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    if_id_reg u_if_id_reg (
        .clk    (clk),
        .rst    (rst),
        .freeze (idr_hold),
        .flush  (idr_flush),
        .load   (idr_load),
        .d      (idr_d),
        .q      (idr_q)
    );

    assign imem_req    = (state_q == WAIT) || (state_q == DROP);
    assign imem_addr   = addr_q;
    assign if_id_pc    = idr_q.pc;
    assign if_id_instr = idr_q.instr;
    assign if_id_valid = idr_q.valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a transaction-level fetch model checked
// every cycle, plus literal expectations at the interesting points.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        v;
    } ent_t;

    int   total = 0;
    int   bad   = 0;

    // Model: fetch pointer, bus address, whether the bus request is unwanted,
    // and a queue of fetched words waiting behind a stall.
    logic        m_started;
    logic        m_stale;
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    ent_t        m_skid[$];
    ent_t        m_ifid;
    ent_t        bub;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_stale   = 1'b0;
        m_pc      = 32'h0;
        m_addr    = 32'h0;
        m_skid.delete();
        m_ifid    = bub;
    endtask

    task automatic model_step();
        ent_t nxt;
        ent_t e;
        nxt = freeze ? m_ifid : bub;
        if (!m_started) begin
            m_started = 1'b1;
            if (branch_taken) begin
                m_pc = branch_addr; m_addr = branch_addr; nxt = bub;
            end
        end else if (m_skid.size() != 0) begin
            if (branch_taken) begin
                m_skid.delete(); m_pc = branch_addr; m_addr = branch_addr; nxt = bub;
            end else if (!freeze) begin
                nxt = m_skid.pop_front();
            end
        end else if (m_stale) begin
            if (branch_taken) begin
                m_pc = branch_addr; nxt = bub;
            end else if (imem_ack) begin
                m_stale = 1'b0; m_addr = m_pc;
            end
        end else begin
            if (branch_taken) begin
                m_pc = branch_addr; nxt = bub;
                if (imem_ack) m_addr = branch_addr;
                else m_stale = 1'b1;
            end else if (imem_ack) begin
                e.pc = m_addr + 32'd4; e.instr = imem_rdata; e.v = 1'b1;
                m_pc = m_addr + 32'd4; m_addr = m_pc;
                if (freeze) m_skid.push_back(e);
                else nxt = e;
            end
        end
        m_ifid = nxt;
    endtask

    task automatic check_model();
        chk("imem_req",    imem_req,    m_started && (m_skid.size() == 0));
        chk("imem_addr",   imem_addr,   m_addr);
        chk("if_id_valid", if_id_valid, m_ifid.v);
        chk("if_id_pc",    if_id_pc,    m_ifid.pc);
        chk("if_id_instr", if_id_instr, m_ifid.instr);
    endtask

    // Memory returns its own address as the instruction word.
    task automatic drive(input logic br, input logic [31:0] ba, input logic fr, input logic ack);
        branch_taken = br;
        branch_addr  = ba;
        freeze       = fr;
        imem_ack     = ack;
        imem_rdata   = ack ? m_addr : 32'hDEAD_BEEF;
    endtask

    task automatic cyc(input logic br, input logic [31:0] ba, input logic fr, input logic ack);
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        check_model();
        drive(br, ba, fr, ack);
    endtask

    logic [34:0] vec [12];
    logic [34:0] v;

    initial begin
        bub.pc = 32'h0; bub.instr = 32'h0; bub.v = 1'b0;
        model_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0);

        // reset state
        cyc(0, 0, 0, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h0);
        cyc(0, 0, 0, 0);
        rst = 1'b0;
        drive(0, 0, 0, 1);

        // streaming acks
        cyc(0, 0, 0, 1);
        chk("first_valid", if_id_valid, 0);
        cyc(0, 0, 0, 1);
        chk("s_pc4", if_id_pc, 32'd4);
        chk("s_in0", if_id_instr, 32'd0);
        chk("s_v4", if_id_valid, 1);
        cyc(0, 0, 1, 1);
        chk("s_pc8", if_id_pc, 32'd8);

        // freeze while the addr-8 word returns
        cyc(0, 0, 1, 1);
        chk("buf_req", imem_req, 0);
        chk("buf_hold_pc", if_id_pc, 32'd8);
        chk("buf_hold_in", if_id_instr, 32'd4);
        cyc(0, 0, 1, 0);
        chk("buf_req2", imem_req, 0);
        cyc(0, 0, 0, 0);
        chk("buf_hold_pc2", if_id_pc, 32'd8);
        cyc(0, 0, 0, 1);
        chk("drain_pc", if_id_pc, 32'd12);
        chk("drain_in", if_id_instr, 32'd8);
        chk("drain_addr", imem_addr, 32'd12);

        // branch while 0x10 is outstanding, ack arrives 2 cycles later
        cyc(1, 32'h100, 0, 0);
        chk("pre_br_addr", imem_addr, 32'h10);
        cyc(0, 0, 0, 0);
        chk("drop_valid", if_id_valid, 0);
        chk("drop_addr", imem_addr, 32'h10);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_valid", if_id_valid, 0);
        cyc(1, 32'h200, 1, 1);
        chk("br_pc", if_id_pc, 32'h104);
        chk("br_in", if_id_instr, 32'h100);

        // branch + freeze + ack together
        cyc(1, 32'hFFFF_FFFC, 0, 1);
        chk("bfa_valid", if_id_valid, 0);
        chk("bfa_instr", if_id_instr, 32'h0);
        chk("bfa_addr", imem_addr, 32'h200);

        // address wrap
        cyc(0, 0, 0, 1);
        chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
        cyc(0, 0, 1, 1);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pc", if_id_pc, 32'h0);
        chk("wrap_in", if_id_instr, 32'hFFFF_FFFC);

        // branch out of BUF, then branches while in DROP
        cyc(1, 32'h300, 1, 0);
        cyc(1, 32'h400, 0, 0);
        chk("bufbr_addr", imem_addr, 32'h300);
        chk("bufbr_valid", if_id_valid, 0);
        cyc(1, 32'h500, 0, 0);
        cyc(0, 0, 0, 1);
        chk("dropbr_addr", imem_addr, 32'h300);
        cyc(0, 0, 0, 1);
        chk("dropbr_redir", imem_addr, 32'h500);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("frz_hold_pc", if_id_pc, 32'h504);
        chk("frz_hold_req", imem_req, 1);

        // asynchronous reset mid-WAIT
        cyc(0, 0, 0, 0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("arst_req", imem_req, 0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_valid", if_id_valid, 0);
        chk("arst_pc", if_id_pc, 32'h0);
        cyc(0, 0, 0, 1);
        rst = 1'b0;
        drive(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("restart_addr", imem_addr, 32'h0);
        chk("restart_req", imem_req, 1);
        cyc(0, 0, 0, 0);
        chk("restart_pc", if_id_pc, 32'd4);

        // branch taken in IDLE
        rst = 1'b1;
        cyc(0, 0, 0, 0);
        rst = 1'b0;
        drive(1, 32'h80, 0, 1);
        cyc(0, 0, 0, 0);
        chk("idle_br_addr", imem_addr, 32'h80);
        chk("idle_br_valid", if_id_valid, 0);

        // mixed sequence: {br, fr, ack, branch_addr}
        vec = '{
            {3'b001, 32'h0}, {3'b011, 32'h0},    {3'b011, 32'h0}, {3'b000, 32'h0},
            {3'b001, 32'h0}, {3'b100, 32'h40},   {3'b010, 32'h0}, {3'b001, 32'h0},
            {3'b011, 32'h0}, {3'b110, 32'h1000}, {3'b001, 32'h0}, {3'b000, 32'h0}
        };
        for (int i = 0; i < 12; i++) begin
            v = vec[i];
            cyc(v[34], v[31:0], v[33], v[32]);
        end
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
